// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM plus ALU/immediate decoders driving the multi-cycle RV32I datapath
`timescale 1ns/1ps
module multicycle_controller #(
    parameter bit          ENABLE_BNE  = 1'b1,
    parameter bit          ENABLE_LUI  = 1'b1,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             op,
    input  logic [2:0]             funct3,
    input  logic                   funct7_5,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic                   adr_src,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic                   reg_write,
    output logic [1:0]             result_src,
    output logic [1:0]             alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [2:0]             imm_src,
    output logic [2:0]             alu_control,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] instret
);
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
        EXECI, ALUWB, BRANCH, JAL, LUI, HALT
    } state_t;

    state_t state, next;
    logic [2:0] f3_alu;
    logic f3_ok, br_ok, br_take, retire;
    logic req_s, mw_s, ir_s, pc_s, rw_s;

    // funct3 to ALU operation for register and immediate arithmetic
    always_comb begin
        f3_ok = 1'b1;
        case (funct3)
            3'b000: f3_alu = (op[5] & funct7_5) ? 3'b001 : 3'b000;
            3'b100: f3_alu = 3'b100;
            3'b110: f3_alu = 3'b011;
            3'b111: f3_alu = 3'b010;
            3'b010: f3_alu = 3'b101;
            default: begin
                f3_alu = 3'b000;
                f3_ok = 1'b0;
            end
        endcase
    end

    assign br_ok = (funct3 == 3'b000) || (ENABLE_BNE && funct3 == 3'b001);
    assign br_take = (funct3 == 3'b000) ? zero : ~zero;

    assign imm_src = (op == OP_LOAD || op == OP_I) ? 3'b000 :
                     (op == OP_STORE)              ? 3'b001 :
                     (op == OP_BRANCH)             ? 3'b010 :
                     (op == OP_JAL)                ? 3'b011 :
                     (op == OP_LUI)                ? 3'b100 : 3'b000;

    // next state, retirement and per-state mux/strobe decode
    always_comb begin
        next = state;
        retire = 1'b0;
        req_s = 1'b0;
        adr_src = 1'b0;
        mw_s = 1'b0;
        ir_s = 1'b0;
        pc_s = 1'b0;
        rw_s = 1'b0;
        result_src = 2'b00;
        alu_src_a = 2'b00;
        alu_src_b = 2'b00;
        alu_control = 3'b000;
        case (state)
            FETCH: begin
                req_s = 1'b1;
                alu_src_b = 2'b10;
                result_src = 2'b10;
                ir_s = mem_ready;
                pc_s = mem_ready;
                next = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                next = (op == OP_LOAD || op == OP_STORE) ? MEMADR :
                       (op == OP_R)                      ? EXECR  :
                       (op == OP_I)                      ? EXECI  :
                       (op == OP_BRANCH)                 ? BRANCH :
                       (op == OP_JAL)                    ? JAL    :
                       (ENABLE_LUI && op == OP_LUI)      ? LUI    : HALT;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                next = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                req_s = 1'b1;
                adr_src = 1'b1;
                next = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src = 2'b01;
                rw_s = 1'b1;
                retire = 1'b1;
                next = FETCH;
            end
            MEMWRITE: begin
                req_s = 1'b1;
                adr_src = 1'b1;
                mw_s = 1'b1;
                retire = mem_ready;
                next = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_control = f3_alu;
                next = f3_ok ? ALUWB : HALT;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_control = f3_alu;
                next = f3_ok ? ALUWB : HALT;
            end
            ALUWB: begin
                rw_s = 1'b1;
                retire = 1'b1;
                next = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_control = 3'b001;
                pc_s = br_ok & br_take;
                retire = br_ok;
                next = br_ok ? FETCH : HALT;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_s = 1'b1;
                next = ALUWB;
            end
            LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                next = ALUWB;
            end
            default: next = HALT;
        endcase
    end

    // strobes are held off for as long as reset is low, abandoning any access in flight
    assign mem_req = req_s & rst;
    assign mem_write = mw_s & rst;
    assign ir_write = ir_s & rst;
    assign pc_write = pc_s & rst;
    assign reg_write = rw_s & rst;
    assign illegal = (state == HALT) & rst;

    // state register and retired-instruction counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
            instret <= '0;
        end else begin
            state <= next;
            if (retire) instret <= instret + COUNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of the multi-cycle control FSM
`timescale 1ns/1ps
module tb_multicycle_controller;
    localparam logic [14:0] F_RDY  = 15'b100110_10_00_10_000;
    localparam logic [14:0] F_WAIT = 15'b100000_10_00_10_000;
    localparam logic [14:0] RSTV   = 15'b000000_10_00_10_000;
    localparam logic [14:0] DEC    = 15'b000000_00_01_01_000;
    localparam logic [14:0] MADR   = 15'b000000_00_10_01_000;
    localparam logic [14:0] MRD    = 15'b110000_00_00_00_000;
    localparam logic [14:0] MWB    = 15'b000001_01_00_00_000;
    localparam logic [14:0] MWR    = 15'b111000_00_00_00_000;
    localparam logic [14:0] EXR    = 15'b000000_00_10_00_000;
    localparam logic [14:0] EXI    = 15'b000000_00_10_01_000;
    localparam logic [14:0] AWB    = 15'b000001_00_00_00_000;
    localparam logic [14:0] BR1    = 15'b000010_00_10_00_001;
    localparam logic [14:0] BR0    = 15'b000000_00_10_00_001;
    localparam logic [14:0] JALV   = 15'b000010_00_01_10_000;
    localparam logic [14:0] LUIV   = 15'b000000_00_11_01_000;
    localparam logic [14:0] HLT    = 15'b000000_00_00_00_000;

    logic clk = 1'b0;
    logic rst, funct7_5, zero, mem_ready;
    logic [6:0] op;
    logic [2:0] funct3;
    logic mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src, alu_control;
    logic [31:0] instret;
    logic a_mem_req, a_adr_src, a_mem_write, a_ir_write, a_pc_write, a_reg_write, a_illegal;
    logic [1:0] a_result_src, a_alu_src_a, a_alu_src_b;
    logic [2:0] a_imm_src, a_alu_control;
    logic [3:0] a_instret;
    logic [14:0] sig, a_sig;
    int checks = 0;
    int errors = 0;
    int hold;
    logic [2:0] f3s [4] = '{3'b100, 3'b110, 3'b111, 3'b010};
    logic [2:0] alus [4] = '{3'b100, 3'b011, 3'b010, 3'b101};

    always #5 clk = ~clk;

    assign sig = {mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
                  result_src, alu_src_a, alu_src_b, alu_control};
    assign a_sig = {a_mem_req, a_adr_src, a_mem_write, a_ir_write, a_pc_write, a_reg_write,
                    a_result_src, a_alu_src_a, a_alu_src_b, a_alu_control};

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
        .illegal(illegal), .instret(instret)
    );

    multicycle_controller #(.ENABLE_BNE(1'b0), .ENABLE_LUI(1'b0), .COUNT_WIDTH(4)) alt (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(a_mem_req), .adr_src(a_adr_src),
        .mem_write(a_mem_write), .ir_write(a_ir_write), .pc_write(a_pc_write),
        .reg_write(a_reg_write), .result_src(a_result_src), .alu_src_a(a_alu_src_a),
        .alu_src_b(a_alu_src_b), .imm_src(a_imm_src), .alu_control(a_alu_control),
        .illegal(a_illegal), .instret(a_instret)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic rdy);
        @(negedge clk);
        mem_ready = rdy;
        #1;
    endtask

    task automatic step(input string tag, input logic rdy, input logic [14:0] exp);
        tick(rdy);
        check(tag, 32'(sig), 32'(exp));
    endtask

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_sig", 32'(sig), 32'(RSTV));
        check("rst_instret", instret, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_alt_sig", 32'(a_sig), 32'(RSTV));
        @(negedge clk);
        rst = 1'b1;
        mem_ready = rdy;
        #1;
        check("fetch_after_rst", 32'(sig), 32'(rdy ? F_RDY : F_WAIT));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        op = '0;
        funct3 = '0;
        funct7_5 = 1'b0;
        zero = 1'b0;
        mem_ready = 1'b1;
        do_reset(1'b1);
        op = 7'b0110011;
        step("add_dec", 1'b0, DEC);
        step("add_exec", 1'b0, EXR | 15'd0);
        step("add_wb", 1'b0, AWB);
        check("add_instret_pre", instret, 32'd0);
        step("add_fetch", 1'b1, F_RDY);
        check("add_instret", instret, 32'd1);
        funct7_5 = 1'b1;
        step("sub_dec", 1'b0, DEC);
        step("sub_exec", 1'b0, EXR | 15'd1);
        step("sub_wb", 1'b0, AWB);
        step("sub_fetch", 1'b1, F_RDY);
        check("sub_instret", instret, 32'd2);
        funct7_5 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            funct3 = f3s[i];
            step("r_dec", 1'b0, DEC);
            step("r_exec", 1'b0, EXR | 15'(alus[i]));
            step("r_wb", 1'b0, AWB);
            step("r_fetch", 1'b1, F_RDY);
        end
        check("r_instret", instret, 32'd6);
        funct3 = 3'b001;
        step("bad_f3_dec", 1'b0, DEC);
        tick(1'b1);
        tick(1'b1);
        check("bad_f3_halt", 32'(sig), 32'(HLT));
        check("bad_f3_illegal", 32'(illegal), 32'd1);

        do_reset(1'b0);
        op = 7'b0000011;
        funct3 = 3'b010;
        step("lw_fwait2", 1'b0, F_WAIT);
        step("lw_fwait3", 1'b0, F_WAIT);
        step("lw_fetch", 1'b1, F_RDY);
        step("lw_dec", 1'b0, DEC);
        check("lw_imm", 32'(imm_src), 32'd0);
        step("lw_madr", 1'b0, MADR);
        step("lw_mrd1", 1'b0, MRD);
        step("lw_mrd2", 1'b0, MRD);
        step("lw_mrd3", 1'b0, MRD);
        step("lw_mrd4", 1'b1, MRD);
        step("lw_mwb", 1'b0, MWB);
        check("lw_instret_pre", instret, 32'd0);
        step("lw_fetch_next", 1'b0, F_WAIT);
        check("lw_instret", instret, 32'd1);
        op = 7'b0100011;
        step("sw_fetch", 1'b1, F_RDY);
        step("sw_dec", 1'b0, DEC);
        step("sw_madr", 1'b0, MADR);
        check("sw_imm", 32'(imm_src), 32'd1);
        step("sw_mwr1", 1'b0, MWR);
        step("sw_mwr2", 1'b1, MWR);
        step("sw_fetch_next", 1'b0, F_WAIT);
        check("sw_instret", instret, 32'd2);
        op = 7'b0000011;
        step("abort_fetch", 1'b1, F_RDY);
        step("abort_dec", 1'b0, DEC);
        step("abort_madr", 1'b0, MADR);
        step("abort_mrd", 1'b0, MRD);
        #2;
        rst = 1'b0;
        #1;
        check("abort_strobes", 32'(sig), 32'(RSTV));

        do_reset(1'b1);
        op = 7'b1100011;
        funct3 = 3'b000;
        zero = 1'b1;
        step("beq_dec", 1'b0, DEC);
        check("beq_imm", 32'(imm_src), 32'd2);
        step("beq_branch", 1'b0, BR1);
        step("beq_fetch", 1'b1, F_RDY);
        check("beq_instret", instret, 32'd1);
        funct3 = 3'b001;
        step("bne_dec", 1'b0, DEC);
        step("bne_branch", 1'b0, BR0);
        check("bne_alt_branch", 32'(a_sig), 32'(BR0));
        step("bne_fetch", 1'b0, F_WAIT);
        check("bne_instret", instret, 32'd2);
        check("bne_alt_halt", 32'(a_sig), 32'(HLT));
        check("bne_alt_illegal", 32'(a_illegal), 32'd1);
        check("bne_alt_instret", 32'(a_instret), 32'd1);

        do_reset(1'b1);
        op = 7'b1101111;
        zero = 1'b0;
        step("jal_dec", 1'b0, DEC);
        check("jal_imm", 32'(imm_src), 32'd3);
        step("jal_jal", 1'b0, JALV);
        step("jal_wb", 1'b0, AWB);
        step("jal_fetch", 1'b1, F_RDY);
        check("jal_instret", instret, 32'd1);
        op = 7'b0110111;
        step("lui_dec", 1'b0, DEC);
        step("lui_lui", 1'b0, LUIV);
        check("lui_imm", 32'(imm_src), 32'd4);
        check("lui_alt_illegal", 32'(a_illegal), 32'd1);
        check("lui_alt_halt", 32'(a_sig), 32'(HLT));
        step("lui_wb", 1'b0, AWB);
        step("lui_fetch", 1'b1, F_RDY);
        check("lui_instret", instret, 32'd2);
        hold = 0;
        repeat (10) begin
            tick(1'b1);
            if (a_illegal) hold++;
        end
        check("lui_alt_hold", 32'(hold), 32'd10);
        #2;
        rst = 1'b0;
        #1;
        check("lui_alt_cleared", 32'(a_illegal), 32'd0);

        do_reset(1'b1);
        op = 7'b0010011;
        funct3 = 3'b000;
        for (int i = 1; i <= 16; i++) begin
            tick(1'b0);
            tick(1'b0);
            if (i == 1) check("addi_exec", 32'(sig), 32'(EXI));
            tick(1'b0);
            tick(1'b1);
            check("wrap_alt_instret", 32'(a_instret), 32'(i % 16));
        end
        check("wrap_main_instret", instret, 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control unit for the multi-cycle RV32I core, the successor to the single-cycle datapath whose control inputs are currently driven from bench pins. It holds a Moore FSM plus combinational ALU and immediate decoders, and drives every datapath mux, enable and memory strobe. It adds behaviour the single-cycle core lacks: a shared instruction/data memory with a req/ready handshake, optional BNE and LUI support, an illegal-opcode halt, and a retired-instruction counter.

Parameters:
ENABLE_BNE, 1, when 1, B-type funct3=001 branches on ~zero; when 0, B-type with funct3≠000 is illegal
ENABLE_LUI, 1, when 1, opcode 0110111 is supported; when 0, it is illegal
COUNT_WIDTH, 32, width of the retired-instruction counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
op  input  7  instr[6:0] from the instruction register
funct3  input  3  instr[14:12]
funct7_5  input  1  instr[30]
zero  input  1  ALU zero flag
mem_ready  input  1  memory has completed the current access this cycle
mem_req  output  1  memory access request
adr_src  output  1  0 = PC, 1 = ALUOut drives the memory address
mem_write  output  1  memory write strobe
ir_write  output  1  load IR and OldPC
pc_write  output  1  PC load enable
reg_write  output  1  register file write enable
result_src  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult
alu_src_a  output  2  00 = PC, 01 = OldPC, 10 = rs1 (A), 11 = constant 0
alu_src_b  output  2  00 = rs2 (WriteData), 01 = immExt, 10 = constant 4
imm_src  output  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
alu_control  output  3  000 = add, 001 = sub, 010 = and, 011 = or, 100 = xor, 101 = slt
illegal  output  1  controller is halted on an unsupported opcode or funct3
instret  output  COUNT_WIDTH  count of retired instructions

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, HALT. The state register is the only flop apart from instret.
- Reset (rst=0, asynchronous): state=FETCH, instret=0. While rst=0, mem_req, mem_write, ir_write, pc_write, reg_write and illegal are forced to 0. Mux selects show the FETCH encoding.
- ALU op per state: FETCH, DECODE, MEMADR, JAL and LUI add; BRANCH subtracts; EXECR and EXECI use funct3.
- funct3 decode: 000 gives sub if op[5]&funct7_5, else add; 100 = xor; 110 = or; 111 = and; 010 = slt. Any other funct3 in EXECR/EXECI goes to HALT.
- imm_src is combinational from op in every state: load/OP-IMM = I, store = S, branch = B, jal = J, lui = U; any other op gives 000.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10. ir_write and pc_write assert only in the cycle mem_ready=1, and the FSM moves to DECODE only on that cycle. Otherwise it holds FETCH indefinitely.
- DECODE (alu_src_a=01, alu_src_b=01) routes on op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI if ENABLE_LUI
  - otherwise -> HALT
- MEMADR: alu_src_a=10, alu_src_b=01. Goes to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, adr_src=1, mem_write=1, held through every wait cycle. Goes to FETCH on mem_ready.
- EXECR: alu_src_a=10, alu_src_b=00, then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, result_src=00. pc_write = zero for funct3=000, and ~zero for 001 when ENABLE_BNE. Then FETCH. Any other funct3 goes to HALT with pc_write=0.
- JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_write=1, then ALUWB.
- LUI: alu_src_a=11, alu_src_b=01, then ALUWB.
- HALT: illegal=1, all strobes 0. Held until reset.
- instret increments by 1, wrapping modulo 2^COUNT_WIDTH, on each clock edge that moves the FSM to FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- An asynchronous reset during a memory wait abandons the access immediately, with no further strobe.

Test Plan:
- Reset low for 3 cycles with mem_ready=1 -> all strobes 0, instret=0. After release: FETCH, mem_req=1, ir_write=1, pc_write=1 in the same cycle.
- add (op=0110011, funct3=000, funct7_5=0), mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB, FETCH with alu_control=000 in EXECR and reg_write=1 in ALUWB; instret 0->1. Repeat with funct7_5=1 -> alu_control=001.
- lw with mem_ready low for 3 cycles in both FETCH and MEMREAD -> FETCH held 4 cycles, then MEMREAD held 4 cycles with adr_src=1 and mem_req=1; ir_write pulses exactly once; MEMWB has result_src=01; total 11 cycles.
- beq (funct3=000) with zero=1 -> pc_write=1 in BRANCH. bne (funct3=001) with zero=1 -> pc_write=0. bne with ENABLE_BNE=0 -> HALT, illegal=1.
- jal, then lui with ENABLE_LUI=1 -> JAL asserts pc_write=1 and is followed by ALUWB; LUI has alu_src_a=11, imm_src=100. With ENABLE_LUI=0, lui -> HALT; illegal stays 1 for 10 cycles and clears only on rst=0.
- Preset instret to all-ones by retiring 2^COUNT_WIDTH−1 instructions with COUNT_WIDTH=4 (15 addi) -> the 16th retirement wraps instret to 0.
